// File: rtl/st_sink_ram_writer.sv
// Avalon-ST packet sink that stores each accepted beat as one word of a single-port RAM.
// It reports a descriptor per completed packet, a packet counter and sticky protocol-error flags.
module st_sink_ram_writer #(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 10,
  parameter int EMPTY_W = $clog2(WIDTH/8)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   snk_data,
  input  logic               snk_valid,
  output logic               snk_ready,
  input  logic               snk_sop,
  input  logic               snk_eop,
  input  logic [EMPTY_W-1:0] snk_empty,
  input  logic               buf_clear,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [WIDTH-1:0]   ram_data,
  output logic               ram_wren,
  output logic               pkt_done,
  output logic [ADDR_W-1:0]  pkt_base,
  output logic [ADDR_W:0]    pkt_len,
  output logic [EMPTY_W-1:0] pkt_empty,
  output logic [7:0]         pkt_count,
  output logic [ADDR_W:0]    fill_level,
  output logic [2:0]         err_flags
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_IN_PKT = 2'd1,
    S_FULL   = 2'd2,
    S_DROP   = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t          state_r, state_s;
  logic [ADDR_W:0] wr_ptr_r, wr_ptr_s;
  logic [ADDR_W:0] base_r, base_s;
  logic [ADDR_W:0] addr_s;
  logic            mid_r, mid_s;
  logic [2:0]      err_r, err_s;
  logic [7:0]      count_r;
  logic            ready_r;
  logic            xfer_s;
  logic            store_s;
  logic            done_s;

  assign xfer_s     = snk_valid & ready_r;
  assign snk_ready  = ready_r;
  assign fill_level = wr_ptr_r;
  assign err_flags  = err_r;
  assign pkt_count  = count_r;

  // Next-state, write decision and pointer arithmetic; mid_s remembers whether FULL cut a packet.
  always_comb begin
    state_s  = state_r;
    wr_ptr_s = wr_ptr_r;
    base_s   = base_r;
    mid_s    = mid_r;
    err_s    = err_r;
    addr_s   = wr_ptr_r;
    store_s  = 1'b0;
    done_s   = 1'b0;
    if (buf_clear) begin
      wr_ptr_s = {(ADDR_W+1){1'b0}};
      mid_s    = 1'b0;
      if ((state_r == S_IN_PKT) || ((state_r == S_FULL) && mid_r)) begin
        state_s = S_DROP;
      end else begin
        state_s = S_IDLE;
      end
    end else if (xfer_s) begin
      if ((state_r == S_IN_PKT) || (snk_sop && (state_r != S_FULL))) begin
        store_s = 1'b1;
        if (snk_sop) begin
          // A sop inside a packet abandons it and restarts at its base.
          if (state_r == S_IN_PKT) begin
            err_s[1] = 1'b1;
            addr_s   = base_r;
          end else begin
            addr_s   = wr_ptr_r;
          end
          base_s = addr_s;
        end else begin
          addr_s = wr_ptr_r;
        end
        wr_ptr_s = addr_s + ONE;
        if (snk_eop) begin
          done_s  = 1'b1;
          state_s = S_IDLE;
        end else begin
          state_s = S_IN_PKT;
        end
        if (wr_ptr_s == DEPTH) begin
          state_s  = S_FULL;
          mid_s    = ~snk_eop;
          err_s[2] = err_r[2] | ~snk_eop;
        end else begin
          mid_s    = 1'b0;
        end
      end else if (state_r == S_IDLE) begin
        err_s[0] = 1'b1;
      end else if ((state_r == S_DROP) && snk_eop) begin
        state_s = S_IDLE;
      end else begin
        state_s = state_r;
      end
    end else begin
      state_s = state_r;
    end
  end

  // State, pointers, RAM write port and packet descriptor registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      wr_ptr_r  <= {(ADDR_W+1){1'b0}};
      base_r    <= {(ADDR_W+1){1'b0}};
      mid_r     <= 1'b0;
      err_r     <= 3'b000;
      count_r   <= 8'd0;
      ready_r   <= 1'b0;
      ram_addr  <= {ADDR_W{1'b0}};
      ram_data  <= {WIDTH{1'b0}};
      ram_wren  <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_base  <= {ADDR_W{1'b0}};
      pkt_len   <= {(ADDR_W+1){1'b0}};
      pkt_empty <= {EMPTY_W{1'b0}};
    end else begin
      state_r  <= state_s;
      wr_ptr_r <= wr_ptr_s;
      base_r   <= base_s;
      mid_r    <= mid_s;
      err_r    <= err_s;
      ready_r  <= (state_s != S_FULL);
      ram_addr <= addr_s[ADDR_W-1:0];
      ram_data <= snk_data;
      ram_wren <= store_s;
      pkt_done <= done_s;
      if (done_s) begin
        pkt_base  <= base_s[ADDR_W-1:0];
        pkt_len   <= wr_ptr_s - base_s;
        pkt_empty <= snk_empty;
        count_r   <= count_r + 8'd1;
      end else begin
        count_r   <= count_r;
      end
    end
  end

endmodule

// File: tb/tb_st_sink_ram_writer.sv
// Directed self-checking bench for st_sink_ram_writer with a 16-word buffer.
module tb_st_sink_ram_writer;

  localparam int WIDTH   = 32;
  localparam int ADDR_W  = 4;
  localparam int EMPTY_W = 2;

  logic               clk;
  logic               rst;
  logic [WIDTH-1:0]   snk_data;
  logic               snk_valid;
  logic               snk_ready;
  logic               snk_sop;
  logic               snk_eop;
  logic [EMPTY_W-1:0] snk_empty;
  logic               buf_clear;
  logic [ADDR_W-1:0]  ram_addr;
  logic [WIDTH-1:0]   ram_data;
  logic               ram_wren;
  logic               pkt_done;
  logic [ADDR_W-1:0]  pkt_base;
  logic [ADDR_W:0]    pkt_len;
  logic [EMPTY_W-1:0] pkt_empty;
  logic [7:0]         pkt_count;
  logic [ADDR_W:0]    fill_level;
  logic [2:0]         err_flags;

  int vectors;
  int miscompares;

  st_sink_ram_writer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .EMPTY_W(EMPTY_W)) dut (
    .clk(clk), .rst(rst),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
    .snk_sop(snk_sop), .snk_eop(snk_eop), .snk_empty(snk_empty),
    .buf_clear(buf_clear),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
    .pkt_done(pkt_done), .pkt_base(pkt_base), .pkt_len(pkt_len),
    .pkt_empty(pkt_empty), .pkt_count(pkt_count),
    .fill_level(fill_level), .err_flags(err_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic s, input logic e, input logic [1:0] emp);
    snk_valid = 1'b1;
    snk_data  = d;
    snk_sop   = s;
    snk_eop   = e;
    snk_empty = emp;
  endtask

  task automatic chk_write(input string tag, input logic [3:0] a, input logic [31:0] d);
    chk({tag, "_wren"}, ram_wren, 1);
    chk({tag, "_addr"}, ram_addr, a);
    chk({tag, "_data"}, ram_data, d);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, snk_ready, 0);
    chk({tag, "_wren"},  ram_wren, 0);
    chk({tag, "_addr"},  ram_addr, 0);
    chk({tag, "_data"},  ram_data, 0);
    chk({tag, "_done"},  pkt_done, 0);
    chk({tag, "_base"},  pkt_base, 0);
    chk({tag, "_len"},   pkt_len, 0);
    chk({tag, "_empty"}, pkt_empty, 0);
    chk({tag, "_count"}, pkt_count, 0);
    chk({tag, "_fill"},  fill_level, 0);
    chk({tag, "_err"},   err_flags, 0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    snk_valid = 1'b0; snk_data = 32'h0; snk_sop = 1'b0; snk_eop = 1'b0;
    snk_empty = 2'd0; buf_clear = 1'b0;
    tick(); tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();
    chk("ready_after_reset", snk_ready, 1);

    // 3-beat packet, continuous valid
    beat(32'hA0, 1'b1, 1'b0, 2'd0); tick();
    chk_write("p1b0", 4'd0, 32'hA0);
    chk("p1b0_done", pkt_done, 0);
    beat(32'hA1, 1'b0, 1'b0, 2'd0); tick();
    chk_write("p1b1", 4'd1, 32'hA1);
    beat(32'hA2, 1'b0, 1'b1, 2'd2); tick();
    chk_write("p1b2", 4'd2, 32'hA2);
    chk("p1_done", pkt_done, 1);
    chk("p1_base", pkt_base, 0);
    chk("p1_len", pkt_len, 3);
    chk("p1_empty", pkt_empty, 2);
    chk("p1_count", pkt_count, 1);
    chk("p1_fill", fill_level, 3);
    snk_valid = 1'b0; tick();
    chk("p1_idle_wren", ram_wren, 0);
    chk("p1_done_pulse", pkt_done, 0);
    chk("p1_base_hold", pkt_base, 0);

    // single-beat packet
    beat(32'h55, 1'b1, 1'b1, 2'd0); tick();
    chk_write("p2", 4'd3, 32'h55);
    chk("p2_done", pkt_done, 1);
    chk("p2_base", pkt_base, 3);
    chk("p2_len", pkt_len, 1);
    chk("p2_count", pkt_count, 2);
    chk("p2_fill", fill_level, 4);

    // beat outside a packet
    beat(32'h77, 1'b0, 1'b0, 2'd0); tick();
    chk("orphan_wren", ram_wren, 0);
    chk("orphan_err", err_flags, 3'b001);
    chk("orphan_fill", fill_level, 4);

    // sop inside a packet rewinds to its base
    beat(32'h40, 1'b1, 1'b0, 2'd0); tick();
    chk_write("p3b0", 4'd4, 32'h40);
    beat(32'h41, 1'b1, 1'b0, 2'd0); tick();
    chk_write("p3_resop", 4'd4, 32'h41);
    chk("p3_resop_err", err_flags, 3'b011);
    chk("p3_resop_done", pkt_done, 0);
    chk("p3_resop_fill", fill_level, 5);
    beat(32'h42, 1'b0, 1'b1, 2'd0); tick();
    chk_write("p3b1", 4'd5, 32'h42);
    chk("p3_done", pkt_done, 1);
    chk("p3_base", pkt_base, 4);
    chk("p3_len", pkt_len, 2);
    chk("p3_count", pkt_count, 3);

    // clear, then overflow with a 20-beat packet
    snk_valid = 1'b0; buf_clear = 1'b1; tick();
    buf_clear = 1'b0;
    chk("clear_fill", fill_level, 0);
    for (int i = 0; i < 16; i++) begin
      beat(32'h100 + 32'(i), (i == 0), 1'b0, 2'd0); tick();
      chk_write("ovf", 4'(i), 32'h100 + 32'(i));
    end
    chk("ovf_ready", snk_ready, 0);
    chk("ovf_err", err_flags, 3'b111);
    chk("ovf_fill", fill_level, 16);
    chk("ovf_count", pkt_count, 3);
    beat(32'h110, 1'b0, 1'b0, 2'd0); tick();
    chk("full_stall_wren", ram_wren, 0);
    chk("full_stall_ready", snk_ready, 0);
    buf_clear = 1'b1; tick();
    buf_clear = 1'b0;
    chk("full_clear_fill", fill_level, 0);
    chk("full_clear_ready", snk_ready, 1);
    for (int i = 16; i < 20; i++) begin
      beat(32'h100 + 32'(i), 1'b0, (i == 19), 2'd0); tick();
      chk("drop_wren", ram_wren, 0);
      chk("drop_done", pkt_done, 0);
    end
    beat(32'hB0, 1'b1, 1'b1, 2'd3); tick();
    chk_write("after_drop", 4'd0, 32'hB0);
    chk("after_drop_done", pkt_done, 1);
    chk("after_drop_len", pkt_len, 1);
    chk("after_drop_empty", pkt_empty, 3);
    chk("after_drop_count", pkt_count, 4);

    // valid gaps and buf_clear colliding with a valid beat
    snk_valid = 1'b0; tick();
    chk("gap0_wren", ram_wren, 0);
    beat(32'hC0, 1'b1, 1'b0, 2'd0); tick();
    chk_write("gap_c0", 4'd1, 32'hC0);
    snk_valid = 1'b0; tick();
    chk("gap1_wren", ram_wren, 0);
    beat(32'hC1, 1'b0, 1'b0, 2'd0); tick();
    chk_write("gap_c1", 4'd2, 32'hC1);
    chk("gap_fill", fill_level, 3);
    beat(32'hC2, 1'b0, 1'b0, 2'd0); buf_clear = 1'b1; tick();
    buf_clear = 1'b0;
    chk("clr_beat_wren", ram_wren, 0);
    chk("clr_beat_fill", fill_level, 0);
    beat(32'hC3, 1'b0, 1'b1, 2'd0); tick();
    chk("clr_drop_wren", ram_wren, 0);
    chk("clr_drop_done", pkt_done, 0);

    // reset in the middle of a packet
    beat(32'hD0, 1'b1, 1'b0, 2'd0); tick();
    chk_write("rst_d0", 4'd0, 32'hD0);
    beat(32'hD1, 1'b0, 1'b0, 2'd0); tick();
    chk_write("rst_d1", 4'd1, 32'hD1);
    beat(32'hD2, 1'b0, 1'b1, 2'd1); rst = 1'b1; tick();
    chk_reset_outputs("midrst");
    rst = 1'b0; snk_valid = 1'b0; tick();
    chk("post_rst_wren", ram_wren, 0);
    chk("post_rst_done", pkt_done, 0);
    chk("post_rst_ready", snk_ready, 1);
    beat(32'hE0, 1'b1, 1'b1, 2'd1); tick();
    chk_write("post_rst_pkt", 4'd0, 32'hE0);
    chk("post_rst_pkt_done", pkt_done, 1);
    chk("post_rst_pkt_base", pkt_base, 0);
    chk("post_rst_pkt_empty", pkt_empty, 1);
    chk("post_rst_pkt_count", pkt_count, 1);
    snk_valid = 1'b0; tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/st_sink_ram_writer.md
Name: st_sink_ram_writer

Overview:
- Avalon-ST sink that accepts packetised beats and writes each beat as one word into a single-port RAM (ram_v1-style: address, data, wren; 1-cycle write) at incrementing word addresses.
- Receive-side counterpart of the RAM-reader/ST-source test harness; fills the RAM that the reader later plays back.
- Reports per-packet descriptors (base, length, empty), a packet counter for LEDs and sticky protocol-error flags.

Parameters:
- WIDTH, 32, data beat width in bits (multiple of 8).
- ADDR_W, 10, RAM word-address width; DEPTH = 2**ADDR_W words.
- EMPTY_W, $clog2(WIDTH/8), width of snk_empty.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- snk_data  in  WIDTH  beat data.
- snk_valid  in  1  beat valid.
- snk_ready  out  1  sink ready (ready latency 0).
- snk_sop  in  1  start of packet.
- snk_eop  in  1  end of packet.
- snk_empty  in  EMPTY_W  empty bytes on eop beat.
- buf_clear  in  1  rewind buffer, leave FULL.
- ram_addr  out  ADDR_W  RAM word address.
- ram_data  out  WIDTH  RAM write data.
- ram_wren  out  1  RAM write enable.
- pkt_done  out  1  1-cycle pulse: packet completely written.
- pkt_base  out  ADDR_W  first word address of completed packet.
- pkt_len  out  ADDR_W+1  word count of completed packet.
- pkt_empty  out  EMPTY_W  snk_empty of its eop beat.
- pkt_count  out  8  completed packets, wraps 255->0.
- fill_level  out  ADDR_W+1  words written since last clear (= wr_ptr).
- err_flags  out  3  sticky: [0] beat outside packet, [1] sop inside packet, [2] overflow.

Behaviour:
- Transfer = snk_valid && snk_ready on a rising clk edge. snk_ready derives only from registered state, never from snk_valid: 1 in IDLE, IN_PKT, DROP; 0 in FULL and during reset.
- Reset: state IDLE, wr_ptr 0, all outputs 0 (snk_ready, ram_wren, pkt_done, pkt_base, pkt_len, pkt_empty, pkt_count, err_flags).
- Write path: an accepted beat to be stored drives registered ram_addr = wr_ptr[ADDR_W-1:0], ram_data = snk_data, ram_wren = 1 in the cycle after acceptance; wr_ptr increments. ram_wren is 0 in all other cycles.
- States:
  - IDLE: sop beat -> write, pkt_base <= wr_ptr, go IN_PKT. If also eop, packet completes immediately and state stays IDLE. Non-sop beat -> discarded, err[0] set.
  - IN_PKT: beat written. eop -> complete, go IDLE. sop -> err[1] set, wr_ptr rewinds to pkt_base, and the beat is written there as the new packet's first word (abandoned packet gets no pkt_done).
  - FULL: entered when a non-eop write makes wr_ptr == DEPTH. Also entered when an eop write makes wr_ptr == DEPTH, but in that case the packet completes normally. Non-eop entry sets err[2]. ready = 0. buf_clear -> wr_ptr 0; go DROP if the entry was mid-packet, else IDLE.
  - DROP: beats discarded without flagging; the eop beat (discarded) -> IDLE. A sop beat in DROP is treated as the IDLE sop case.
- Completion: pkt_done pulses the cycle after eop acceptance, aligned with the final ram_wren. pkt_len = words written for that packet (1..DEPTH). pkt_base, pkt_len and pkt_empty hold until the next completion. pkt_count increments.
- buf_clear in IDLE/IN_PKT/DROP: wr_ptr <= 0. IN_PKT -> DROP, otherwise IDLE. Any beat accepted in that cycle is discarded. buf_clear has priority over a transfer.
- err_flags cleared only by rst.
- rst mid-packet: immediate return to reset values; the partial packet is lost and no ram_wren follows.

Test Plan:
- ADDR_W=4. Reset, then 3-beat packet 0xA0,0xA1,0xA2 (sop on 1st, eop+empty=2 on 3rd), valid continuous -> ram_wren at addr 0,1,2 with those data; pkt_done once with base 0, len 3, empty 2; pkt_count 1; fill_level 3.
- Single-beat packet sop+eop 0x55 after the above -> write addr 3; pkt_done next cycle, base 3, len 1.
- Beat without sop in IDLE -> no ram_wren, err_flags = 3'b001. Then sop at beat 2 of a packet started at addr 4 -> err[1] set, new packet rewrites addr 4.
- 20-beat packet from empty buffer -> 16 writes (addr 0..15), snk_ready low after 16th, err[2] set. buf_clear -> DROP; remaining 4 beats consumed without writes; next sop packet writes from addr 0.
- Random snk_valid gaps plus pulsed buf_clear concurrent with a valid beat -> beat not written, fill_level 0 next cycle.
- Assert rst mid-packet -> all outputs 0 next cycle; no pkt_done; next packet starts at addr 0.
